// File: rtl/mem_arbiter.sv
// Shares one fixed-latency SRAM port between instruction fetch and load/store.
// MEM wins ties; each access holds address/data stable for WAIT_CYCLES, then pulses ready.
//
//   state    | meaning
//   S_IDLE   | no access; picks MEM over IF when both are requesting
//   S_ACCESS | SRAM enabled with latched operands, counting wait cycles
//   S_DONE   | one-cycle ready pulse to the owner, SRAM disabled
module mem_arbiter #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ready,
    input  logic        i_mem_rd_req,
    input  logic        i_mem_wr_req,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_ready,
    output logic        o_freeze,
    output logic        o_sram_en,
    output logic        o_sram_we,
    output logic [31:0] o_sram_addr,
    output logic [31:0] o_sram_wdata,
    input  logic [31:0] i_sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_mem_req;
    logic        w_start_mem;
    logic        w_start_if;
    logic        w_last;

    logic        r_owner_mem;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_en;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;
    logic        r_if_ready;
    logic        r_mem_ready;

    // Simultaneous read and write requests resolve to a store
    assign w_mem_req = i_mem_rd_req | i_mem_wr_req;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_mem = 1'b0;
        w_start_if  = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_req) begin
                    w_start_mem = 1'b1;
                    w_state_nxt = S_ACCESS;
                end else if (i_if_req) begin
                    w_start_if  = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner_mem <= 1'b0;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_we        <= 1'b0;
            r_en        <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            if (w_start_mem) begin
                r_owner_mem <= 1'b1;
                r_cnt       <= 4'd0;
                r_addr      <= i_mem_addr;
                r_wdata     <= i_mem_wdata;
                r_we        <= i_mem_wr_req;
                r_en        <= 1'b1;
            end else if (w_start_if) begin
                r_owner_mem <= 1'b0;
                r_cnt       <= 4'd0;
                r_addr      <= i_if_addr;
                r_we        <= 1'b0;
                r_en        <= 1'b1;
            end
            if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_last) begin
                r_en <= 1'b0;
                r_we <= 1'b0;
                if (!r_we) begin
                    if (r_owner_mem) begin
                        r_mem_rdata <= i_sram_rdata;
                    end else begin
                        r_if_rdata <= i_sram_rdata;
                    end
                end
                if (r_owner_mem) begin
                    r_mem_ready <= 1'b1;
                end else begin
                    r_if_ready <= 1'b1;
                end
            end
        end
    end

    assign o_freeze     = (i_if_req & ~r_if_ready) | (w_mem_req & ~r_mem_ready);
    assign o_sram_en    = r_en;
    assign o_sram_we    = r_we;
    assign o_sram_addr  = r_addr;
    assign o_sram_wdata = r_wdata;
    assign o_if_rdata   = r_if_rdata;
    assign o_if_ready   = r_if_ready;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_mem_ready  = r_mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_CYCLES=4 instance with a small SRAM model,
// plus a WAIT_CYCLES=1 instance for back-to-back fetch timing.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_errors;

    logic        if_req, mem_rd_req, mem_wr_req;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
    logic        if_ready, mem_ready, freeze, sram_en, sram_we;

    logic        if_req1, mem_rd_req1, mem_wr_req1;
    logic [31:0] if_addr1, mem_addr1, mem_wdata1;
    logic [31:0] if_rdata1, mem_rdata1, sram_addr1, sram_wdata1, sram_rdata1;
    logic        if_ready1, mem_ready1, freeze1, sram_en1, sram_we1;

    logic [31:0] sram_mem [0:1023];
    int          run;

    mem_arbiter #(.WAIT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ready(if_ready),
        .i_mem_rd_req(mem_rd_req), .i_mem_wr_req(mem_wr_req), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata), .o_mem_ready(mem_ready),
        .o_freeze(freeze), .o_sram_en(sram_en), .o_sram_we(sram_we),
        .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req1), .i_if_addr(if_addr1), .o_if_rdata(if_rdata1), .o_if_ready(if_ready1),
        .i_mem_rd_req(mem_rd_req1), .i_mem_wr_req(mem_wr_req1), .i_mem_addr(mem_addr1),
        .i_mem_wdata(mem_wdata1), .o_mem_rdata(mem_rdata1), .o_mem_ready(mem_ready1),
        .o_freeze(freeze1), .o_sram_en(sram_en1), .o_sram_we(sram_we1),
        .o_sram_addr(sram_addr1), .o_sram_wdata(sram_wdata1), .i_sram_rdata(sram_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data is only valid on the 4th consecutive enabled cycle
    always @(posedge clk) begin
        if (rst || !sram_en) run <= 0;
        else                 run <= run + 1;
        if (sram_en && sram_we) sram_mem[sram_addr[11:2]] <= sram_wdata;
    end
    assign sram_rdata  = (sram_en && !sram_we && run == 3) ? sram_mem[sram_addr[11:2]]
                                                           : (32'hBAD0_0000 | 32'(run));
    assign sram_rdata1 = sram_addr1 ^ 32'hA5A5_A5A5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
        sram_mem[4] = 32'hE3A0_1005;   // 0x10
        sram_mem[8] = 32'h1234_5678;   // 0x20
        sram_mem[9] = 32'hCAFE_F00D;   // 0x24
        rst = 1'b1;
        if_req = 0; mem_rd_req = 0; mem_wr_req = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        if_req1 = 0; mem_rd_req1 = 0; mem_wr_req1 = 0;
        if_addr1 = 0; mem_addr1 = 0; mem_wdata1 = 0;

        // Reset values, and freeze tracking its equation during reset
        tick(); tick();
        #1;
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_if_ready", if_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_sram_we", sram_we, 1'b0);
        chk("rst_sram_addr", sram_addr, 32'h0);
        chk("rst_sram_wdata", sram_wdata, 32'h0);
        chk("rst_freeze0", freeze, 1'b0);
        if_req = 1'b1;
        #1;
        chk("rst_freeze1", freeze, 1'b1);
        if_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Fetch from 0x10; if_addr changes in cycle 2 and must not disturb the access
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("f_c0_freeze", freeze, 1'b1);
        chk("f_c0_en", sram_en, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) if_addr = 32'h999;
            #1;
            chk("f_en", sram_en, 1'b1);
            chk("f_we", sram_we, 1'b0);
            chk("f_addr", sram_addr, 32'h10);
            chk("f_freeze", freeze, 1'b1);
            chk("f_ready_early", if_ready, 1'b0);
        end
        tick();
        #1;
        chk("f_ready", if_ready, 1'b1);
        chk("f_rdata", if_rdata, 32'hE3A0_1005);
        chk("f_c5_freeze", freeze, 1'b0);
        chk("f_c5_en", sram_en, 1'b0);
        if_req = 1'b0;
        tick();
        chk("f_ready_pulse", if_ready, 1'b0);
        chk("f_rdata_hold", if_rdata, 32'hE3A0_1005);

        // Store 0xDEADBEEF to 0x400
        tick();
        mem_wr_req = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("st_en", sram_en, 1'b1);
            chk("st_we", sram_we, 1'b1);
            chk("st_addr", sram_addr, 32'h400);
            chk("st_wdata", sram_wdata, 32'hDEAD_BEEF);
        end
        tick();
        chk("st_ready", mem_ready, 1'b1);
        chk("st_we_done", sram_we, 1'b0);
        chk("st_rdata_kept", mem_rdata, 32'h0);
        mem_wr_req = 1'b0;
        tick();

        // Load back from 0x400
        tick();
        mem_rd_req = 1'b1; mem_wdata = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("ld_en", sram_en, 1'b1);
            chk("ld_we", sram_we, 1'b0);
        end
        tick();
        chk("ld_ready", mem_ready, 1'b1);
        chk("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
        mem_rd_req = 1'b0;
        tick();

        // Simultaneous IF and MEM load: MEM first, IF ready in cycle 11
        tick();
        if_req = 1'b1; if_addr = 32'h24;
        mem_rd_req = 1'b1; mem_addr = 32'h20;
        #1;
        chk("sim_c0_freeze", freeze, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk("sim_mem_ready", mem_ready, 32'(c == 5));
            chk("sim_if_ready", if_ready, 32'(c == 11));
            chk("sim_freeze", freeze, 32'(c != 11));
            if (c == 3) chk("sim_mem_addr", sram_addr, 32'h20);
            if (c == 7) chk("sim_if_addr", sram_addr, 32'h24);
            if (c == 5) begin
                chk("sim_mem_rdata", mem_rdata, 32'h1234_5678);
                mem_rd_req = 1'b0;
            end
            if (c == 11) begin
                chk("sim_if_rdata", if_rdata, 32'hCAFE_F00D);
                if_req = 1'b0;
            end
        end
        tick();

        // Reset during cycle 2 of a store
        tick();
        mem_wr_req = 1'b1; mem_addr = 32'h30; mem_wdata = 32'h55;
        tick();
        tick();
        chk("rs_en_before", sram_we, 1'b1);
        rst = 1'b1; mem_wr_req = 1'b0;
        tick();
        chk("rs_en", sram_en, 1'b0);
        chk("rs_we", sram_we, 1'b0);
        chk("rs_addr", sram_addr, 32'h0);
        chk("rs_wdata", sram_wdata, 32'h0);
        chk("rs_if_rdata", if_rdata, 32'h0);
        chk("rs_mem_rdata", mem_rdata, 32'h0);
        chk("rs_freeze", freeze, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rs_no_ready", mem_ready, 1'b0);
            chk("rs_idle_en", sram_en, 1'b0);
        end

        // WAIT_CYCLES=1: held fetch request yields ready in cycles 2, 5, 8
        tick();
        if_req1 = 1'b1; if_addr1 = 32'h40;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk("w1_en", sram_en1, 32'(c % 3 == 1));
            chk("w1_ready", if_ready1, 32'(c % 3 == 2));
            if (c % 3 == 2) chk("w1_rdata", if_rdata1, 32'h40 ^ 32'hA5A5_A5A5);
        end
        if_req1 = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
